pll_reset_supervisor: RTL and testbench

- Drives the reset input of the system PLL (50 MHz ref → 96 MHz / 12 MHz) and monitors its locked output. Together these form the PLL reset/lock handshake.
- Holds the core in reset until lock has been stable for a programmable time.
- Retries the PLL on lock timeout and reports lock losses.
- Sits at the top level in the reference-clock domain, because that clock is valid while the PLL is unlocked. Consumers resynchronise core_reset into their own domains.

---
 rtl/pll_reset_supervisor.sv | 146 ++++++++++++++
 tb/tb_pll_reset_supervisor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_supervisor
// Brief    : Drives the PLL reset, waits for a stable lock, releases the core
//            reset, retries the PLL on lock timeout and counts lock losses.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_DONE = SW'(STABLE_CYCLES);

  localparam logic [2:0] ST_PRST   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state, w_nxt_state;
  logic [PW-1:0]          r_pulse, w_nxt_pulse;
  logic [TW-1:0]          r_timer, w_nxt_timer;
  logic [SW-1:0]          r_stable, w_nxt_stable;
  logic [3:0]             w_nxt_retry, w_retry_inc;
  logic [7:0]             w_nxt_lost;
  logic                   w_locked_s;
  logic                   w_retry_exhausted;

  assign w_locked_s        = r_sync[SYNC_STAGES-1];
  assign w_retry_inc       = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
  assign w_retry_exhausted = (MAX_RETRIES != 0) && (int'({28'd0, w_retry_inc}) > MAX_RETRIES);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_pulse  = r_pulse;
    w_nxt_timer  = r_timer;
    w_nxt_stable = r_stable;
    w_nxt_retry  = retry_cnt;
    w_nxt_lost   = lost_cnt;
    case (r_state)
      ST_PRST: begin
        if (r_pulse == PULSE_LAST) begin
          w_nxt_state = ST_WAIT;
          w_nxt_pulse = '0;
          w_nxt_timer = '0;
        end else begin
          w_nxt_pulse = r_pulse + PW'(1);
        end
      end
      ST_WAIT: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (w_locked_s) begin
          w_nxt_state  = ST_STABLE;
          w_nxt_stable = SW'(1);
        end else if (r_timer == TIMER_LAST) begin
          w_nxt_retry = w_retry_inc;
          w_nxt_timer = '0;
          w_nxt_pulse = '0;
          w_nxt_state = w_retry_exhausted ? ST_FAIL : ST_PRST;
        end else begin
          w_nxt_timer = r_timer + TW'(1);
        end
      end
      ST_STABLE: begin
        // A dropout here is treated as a glitch: re-wait without resetting the PLL.
        if (!w_locked_s) begin
          w_nxt_state  = ST_WAIT;
          w_nxt_timer  = '0;
          w_nxt_stable = '0;
        end else if (r_stable == STABLE_DONE) begin
          w_nxt_state  = ST_RUN;
          w_nxt_stable = '0;
        end else begin
          w_nxt_stable = r_stable + SW'(1);
        end
      end
      ST_RUN: begin
        if (!w_locked_s) begin
          w_nxt_state = ST_WAIT;
          w_nxt_timer = '0;
          w_nxt_retry = 4'd0;
          w_nxt_lost  = (lost_cnt == 8'hFF) ? 8'hFF : lost_cnt + 8'd1;
        end
      end
      ST_FAIL: begin
        w_nxt_state = ST_FAIL;
      end
      default: begin
        w_nxt_state = ST_PRST;
        w_nxt_pulse = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync     <= '0;
      r_state    <= ST_PRST;
      r_pulse    <= '0;
      r_timer    <= '0;
      r_stable   <= '0;
      retry_cnt  <= 4'd0;
      lost_cnt   <= 8'd0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_state    <= w_nxt_state;
      r_pulse    <= w_nxt_pulse;
      r_timer    <= w_nxt_timer;
      r_stable   <= w_nxt_stable;
      retry_cnt  <= w_nxt_retry;
      lost_cnt   <= w_nxt_lost;
      // Outputs decode the next state so they change on the transition edge.
      pll_rst    <= (w_nxt_state == ST_PRST);
      core_reset <= (w_nxt_state != ST_RUN);
      ready      <= (w_nxt_state == ST_RUN);
      fail       <= (w_nxt_state == ST_FAIL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_supervisor.sv
`default_nettype none
// Directed bench for pll_reset_supervisor: expectations queued at stimulus
// time and popped against DUT outputs sampled 1 ns after each refclk edge.
module tb_pll_reset_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  pll_reset_supervisor #(
    .SYNC_STAGES  (2),
    .RST_PULSE    (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .core_reset(core_reset),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset state
    push("rst_pll_rst", 1); push("rst_core_reset", 1); push("rst_ready", 0);
    push("rst_fail", 0); push("rst_retry", 0); push("rst_lost", 0);
    step(2);
    chk(32'(pll_rst)); chk(32'(core_reset)); chk(32'(ready));
    chk(32'(fail)); chk(32'(retry_cnt)); chk(32'(lost_cnt));
    rst = 1'b0;

    // Release: pll_rst high 4 cycles, core_reset falls 10 cycles after lock sampled
    push("pulse_len", 4);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) cnt++;
      step(1);
    end
    chk(32'(cnt));
    pll_locked = 1'b1;
    push("release_early_core", 1);
    step(10);
    chk(32'(core_reset));
    push("release_core", 0); push("release_ready", 1);
    step(1);
    chk(32'(core_reset)); chk(32'(ready));

    // Lock loss from RUN, repeated until lost_cnt saturates
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b0;
      if (k == 1) begin
        push("loss_core_before", 0);
        step(2);
        chk(32'(core_reset));
        step(1);
      end else begin
        step(3);
      end
      push("loss_core", 1);
      chk(32'(core_reset));
      if (k <= 3 || k >= 254) begin
        push("loss_lost", (k > 255) ? 255 : k);
        chk(32'(lost_cnt));
        push("loss_retry", 0);
        chk(32'(retry_cnt));
      end
      pll_locked = 1'b1;
      step(10);
      push("rerelease_early_core", 1);
      chk(32'(core_reset));
      step(1);
      push("rerelease_core", 0);
      chk(32'(core_reset));
    end

    // Reset during STABLE
    do_reset();
    step(10);
    pll_locked = 1'b1;
    step(4);
    push("stable_core", 1);
    chk(32'(core_reset));
    rst = 1'b1;
    push("rst_stable_pll_rst", 1); push("rst_stable_core", 1); push("rst_stable_fail", 0);
    push("rst_stable_retry", 0); push("rst_stable_lost", 0); push("rst_stable_ready", 0);
    step(1);
    chk(32'(pll_rst)); chk(32'(core_reset)); chk(32'(fail));
    chk(32'(retry_cnt)); chk(32'(lost_cnt)); chk(32'(ready));
    rst = 1'b0;
    pll_locked = 1'b0;

    // Glitch in STABLE: back to WAIT, no PLL reset, stable count restarts
    do_reset();
    step(10);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pll_rst) cnt++;
    end
    push("glitch_core_held", 1); push("glitch_pll_rst_pulses", 0);
    chk(32'(core_reset)); chk(32'(cnt));
    step(1);
    push("glitch_core_release", 0); push("glitch_retry", 0);
    chk(32'(core_reset)); chk(32'(retry_cnt));

    // Timeout retries leading to FAIL
    do_reset();
    push("to1_pre_pll_rst", 0); push("to1_pre_retry", 0);
    step(103);
    chk(32'(pll_rst)); chk(32'(retry_cnt));
    push("to1_pll_rst", 1); push("to1_retry", 1); push("to1_core", 1);
    step(1);
    chk(32'(pll_rst)); chk(32'(retry_cnt)); chk(32'(core_reset));
    push("to1_pulse_end_hi", 1);
    step(3);
    chk(32'(pll_rst));
    push("to1_pulse_end_lo", 0);
    step(1);
    chk(32'(pll_rst));
    push("to2_pll_rst", 1); push("to2_retry", 2);
    step(100);
    chk(32'(pll_rst)); chk(32'(retry_cnt));
    push("to3_pre_fail", 0); push("to3_pre_pll_rst", 0);
    step(103);
    chk(32'(fail)); chk(32'(pll_rst));
    push("to3_fail", 1); push("to3_retry", 3); push("to3_pll_rst", 0);
    push("to3_core", 1); push("to3_ready", 0);
    step(1);
    chk(32'(fail)); chk(32'(retry_cnt)); chk(32'(pll_rst));
    chk(32'(core_reset)); chk(32'(ready));
    pll_locked = 1'b1;
    push("fail_sticky", 1); push("fail_sticky_core", 1);
    step(20);
    chk(32'(fail)); chk(32'(core_reset));

    // Reset during FAIL, then lock already high during PRST is ignored
    rst = 1'b1;
    push("rst_fail_fail", 0); push("rst_fail_pll_rst", 1); push("rst_fail_retry", 0);
    step(1);
    chk(32'(fail)); chk(32'(pll_rst)); chk(32'(retry_cnt));
    rst = 1'b0;
    push("prst_ignore_hi", 1);
    step(3);
    chk(32'(pll_rst));
    push("prst_ignore_lo", 0);
    step(1);
    chk(32'(pll_rst));
    push("prst_ignore_core_held", 1);
    step(8);
    chk(32'(core_reset));
    push("prst_ignore_release", 0);
    step(1);
    chk(32'(core_reset));

    // Lock seen on the exact cycle the timer expires: lock wins
    do_reset();
    step(101);
    pll_locked = 1'b1;
    push("sim_pll_rst", 0); push("sim_retry", 0); push("sim_core", 1);
    step(3);
    chk(32'(pll_rst)); chk(32'(retry_cnt)); chk(32'(core_reset));
    push("sim_core_held", 1);
    step(7);
    chk(32'(core_reset));
    push("sim_release", 0); push("sim_release_retry", 0);
    step(1);
    chk(32'(core_reset)); chk(32'(retry_cnt));

    push("scoreboard_drained", 0);
    chk(32'(sbq.size() - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
